// File: rtl/near_path_pipe_pkg.sv
// Shared FPU definitions used by the near-path pipeline.
// Contents:
//   RM_*       rounding-mode encodings (3 bits)
//   lzc_width  width of a leading-zero count for a PRECISION-bit significand
//              extended by one guard bit (the count may reach PRECISION+1)
package near_path_pipe_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Magnitude is PRECISION+1 bits, so the count ranges over 0..PRECISION+1.
  function automatic int lzc_width(input int precision);
    return $clog2(precision + 2);
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading-zero counter.
// Ports:
//   in_i   [WIDTH-1:0]  value to scan from the MSB
//   cnt_o  [CNTW-1:0]   number of leading zeros (WIDTH when in_i is zero)
module lzc #(
  parameter int WIDTH = 49,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNTW-1:0]  cnt_o
);

  // Scan upward; the highest set bit is the last one to overwrite the count.
  always_comb begin
    cnt_o = CNTW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) begin
        cnt_o = CNTW'(WIDTH - 1 - i);
      end else begin
        cnt_o = cnt_o;
      end
    end
  end

endmodule

// File: rtl/near_path_norm.sv
// Near-path normaliser: shift limited by the exponent, result exponent and
// sticky-compressed significand.
// Ports:
//   mag_i    [PRECISION:0]   difference magnitude
//   a_exp_i  [EXPWIDTH-1:0]  biased exponent of the larger operand
//   lz_i     [LZW-1:0]       leading-zero count of mag_i
//   exp_o    [EXPWIDTH-1:0]  normalised exponent (0 when result is subnormal)
//   sig_o    [OUTPC+2:0]     top OUTPC+2 bits of the shifted value plus sticky
module near_path_norm #(
  parameter int EXPWIDTH  = 8,
  parameter int PRECISION = 48,
  parameter int OUTPC     = 24,
  parameter int LZW       = 6
) (
  input  logic [PRECISION:0]  mag_i,
  input  logic [EXPWIDTH-1:0] a_exp_i,
  input  logic [LZW-1:0]      lz_i,
  output logic [EXPWIDTH-1:0] exp_o,
  output logic [OUTPC+2:0]    sig_o
);

  localparam int SHW = (LZW > EXPWIDTH) ? LZW : EXPWIDTH;
  localparam logic [SHW-1:0] SH_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0] SH_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  logic [SHW-1:0]     lz_ext_s;
  logic [SHW-1:0]     exp_ext_s;
  logic [SHW-1:0]     sh_s;
  logic [PRECISION:0] norm_s;

  // Shift by lz, but never so far that the exponent would drop below 1;
  // a zero exponent operand is already subnormal and is left unshifted.
  always_comb begin
    lz_ext_s  = SHW'(lz_i);
    exp_ext_s = SHW'(a_exp_i);
    if (exp_ext_s == SH_ZERO) begin
      sh_s = SH_ZERO;
    end else if (lz_ext_s < exp_ext_s) begin
      sh_s = lz_ext_s;
    end else begin
      sh_s = exp_ext_s - SH_ONE;
    end
    norm_s = mag_i << sh_s;
    // A clear leading bit after the limited shift marks a subnormal result.
    if (norm_s[PRECISION]) begin
      exp_o = a_exp_i - EXPWIDTH'(sh_s);
    end else begin
      exp_o = {EXPWIDTH{1'b0}};
    end
    sig_o = {norm_s[PRECISION -: OUTPC + 2], |norm_s[PRECISION-OUTPC-2:0]};
  end

endmodule

// File: rtl/near_path_pipe.sv
// Near-path (close-exponent) subtract pipeline, two stages, valid/ready.
// Stage 1 aligns B by at most one position, subtracts and takes |diff|;
// stage 2 counts leading zeros and normalises into registered outputs.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   flush_i                        kills both stages on the next edge
//   in_valid_i / in_ready_o        input handshake
//   a_sign_i, a_exp_i, a_sig_i     larger-exponent operand A
//   b_sign_i, b_sig_i              operand B (effective sign)
//   need_shift_b_i                 B is one exponent below A
//   rm_i                           rounding mode
//   tag_i / tag_o                  opaque passthrough tag
//   out_valid_o / out_ready_i      output handshake
//   result_sign_o, result_exp_o, result_sig_o, sig_is_zero_o, a_lt_b_o
module near_path_pipe
  import near_path_pipe_pkg::*;
#(
  parameter int EXPWIDTH  = 8,
  parameter int PRECISION = 48,
  parameter int OUTPC     = 24,
  parameter int TAGW      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 a_sign_i,
  input  logic [EXPWIDTH-1:0]  a_exp_i,
  input  logic [PRECISION-1:0] a_sig_i,
  input  logic                 b_sign_i,
  input  logic [PRECISION-1:0] b_sig_i,
  input  logic                 need_shift_b_i,
  input  logic [2:0]           rm_i,
  input  logic [TAGW-1:0]      tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 result_sign_o,
  output logic [EXPWIDTH-1:0]  result_exp_o,
  output logic [OUTPC+2:0]     result_sig_o,
  output logic                 sig_is_zero_o,
  output logic                 a_lt_b_o,
  output logic [TAGW-1:0]      tag_o
);

  localparam int LZW = lzc_width(PRECISION);
  localparam int DW  = PRECISION + 2;

  if (OUTPC + 3 > PRECISION + 1) begin : g_bad_width
    $error("near_path_pipe: OUTPC+3 must not exceed PRECISION+1");
  end

  logic                 s1_valid_r;
  logic [PRECISION:0]   s1_mag_r;
  logic                 s1_sign_r;
  logic [EXPWIDTH-1:0]  s1_exp_r;
  logic [2:0]           s1_rm_r;
  logic [TAGW-1:0]      s1_tag_r;
  logic                 s1_alb_r;

  logic                 s2_free_s;
  logic                 in_fire_s;
  logic                 s1_adv_s;

  logic [DW-1:0]        a_ext_s;
  logic [DW-1:0]        b_ext_s;
  logic [DW-1:0]        diff_s;
  logic [DW-1:0]        neg_s;
  logic                 alb_s;
  logic [PRECISION:0]   mag_s;
  logic                 sign_s;

  logic [LZW-1:0]       lz_s;
  logic [EXPWIDTH-1:0]  norm_exp_s;
  logic [OUTPC+2:0]     norm_sig_s;
  logic                 zero_s;
  logic                 fin_sign_s;
  logic [EXPWIDTH-1:0]  fin_exp_s;
  logic [OUTPC+2:0]     fin_sig_s;

  assign s2_free_s  = !out_valid_o || out_ready_i;
  assign in_ready_o = !s1_valid_r || s2_free_s;
  assign in_fire_s  = in_valid_i && in_ready_o;
  assign s1_adv_s   = s1_valid_r && s2_free_s;

  // Stage 1 datapath: align, subtract in two's complement, take magnitude.
  always_comb begin
    a_ext_s = {1'b0, a_sig_i, 1'b0};
    b_ext_s = {1'b0, b_sig_i, 1'b0} >> need_shift_b_i;
    diff_s  = a_ext_s - b_ext_s;
    neg_s   = {DW{1'b0}} - diff_s;
    alb_s   = diff_s[DW-1];
    if (alb_s) begin
      mag_s  = neg_s[PRECISION:0];
      sign_s = b_sign_i;
    end else begin
      mag_s  = diff_s[PRECISION:0];
      sign_s = a_sign_i;
    end
  end

  // Stage 1 register: valid follows input fire, drains into stage 2, flush wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_mag_r   <= {(PRECISION+1){1'b0}};
      s1_sign_r  <= 1'b0;
      s1_exp_r   <= {EXPWIDTH{1'b0}};
      s1_rm_r    <= 3'b000;
      s1_tag_r   <= {TAGW{1'b0}};
      s1_alb_r   <= 1'b0;
    end else begin
      if (flush_i) begin
        s1_valid_r <= 1'b0;
      end else if (in_fire_s) begin
        s1_valid_r <= 1'b1;
      end else if (s2_free_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
      if (in_fire_s) begin
        s1_mag_r  <= mag_s;
        s1_sign_r <= sign_s;
        s1_exp_r  <= a_exp_i;
        s1_rm_r   <= rm_i;
        s1_tag_r  <= tag_i;
        s1_alb_r  <= alb_s;
      end else begin
        s1_mag_r  <= s1_mag_r;
        s1_sign_r <= s1_sign_r;
        s1_exp_r  <= s1_exp_r;
        s1_rm_r   <= s1_rm_r;
        s1_tag_r  <= s1_tag_r;
        s1_alb_r  <= s1_alb_r;
      end
    end
  end

  lzc #(
    .WIDTH (PRECISION + 1),
    .CNTW  (LZW)
  ) u_lzc (
    .in_i  (s1_mag_r),
    .cnt_o (lz_s)
  );

  near_path_norm #(
    .EXPWIDTH  (EXPWIDTH),
    .PRECISION (PRECISION),
    .OUTPC     (OUTPC),
    .LZW       (LZW)
  ) u_norm (
    .mag_i   (s1_mag_r),
    .a_exp_i (s1_exp_r),
    .lz_i    (lz_s),
    .exp_o   (norm_exp_s),
    .sig_o   (norm_sig_s)
  );

  // Exact cancellation: zero result whose sign depends only on rounding mode.
  always_comb begin
    zero_s = (s1_mag_r == {(PRECISION+1){1'b0}});
    if (zero_s) begin
      fin_sign_s = (s1_rm_r == RM_RDN);
      fin_exp_s  = {EXPWIDTH{1'b0}};
      fin_sig_s  = {(OUTPC+3){1'b0}};
    end else begin
      fin_sign_s = s1_sign_r;
      fin_exp_s  = norm_exp_s;
      fin_sig_s  = norm_sig_s;
    end
  end

  // Stage 2 / output register: loads only when free, so stalled outputs hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o   <= 1'b0;
      result_sign_o <= 1'b0;
      result_exp_o  <= {EXPWIDTH{1'b0}};
      result_sig_o  <= {(OUTPC+3){1'b0}};
      sig_is_zero_o <= 1'b0;
      a_lt_b_o      <= 1'b0;
      tag_o         <= {TAGW{1'b0}};
    end else begin
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (s2_free_s) begin
        out_valid_o <= s1_valid_r;
      end else begin
        out_valid_o <= out_valid_o;
      end
      if (s1_adv_s) begin
        result_sign_o <= fin_sign_s;
        result_exp_o  <= fin_exp_s;
        result_sig_o  <= fin_sig_s;
        sig_is_zero_o <= zero_s;
        a_lt_b_o      <= s1_alb_r;
        tag_o         <= s1_tag_r;
      end else begin
        result_sign_o <= result_sign_o;
        result_exp_o  <= result_exp_o;
        result_sig_o  <= result_sig_o;
        sig_is_zero_o <= sig_is_zero_o;
        a_lt_b_o      <= a_lt_b_o;
        tag_o         <= tag_o;
      end
    end
  end

endmodule

// File: tb/tb_near_path_pipe.sv
// Testbench for near_path_pipe (EXPWIDTH=8, PRECISION=48, OUTPC=24, TAGW=8).
module tb_near_path_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        a_sign_i = 1'b0;
  logic [7:0]  a_exp_i = 8'd0;
  logic [47:0] a_sig_i = 48'd0;
  logic        b_sign_i = 1'b0;
  logic [47:0] b_sig_i = 48'd0;
  logic        need_shift_b_i = 1'b0;
  logic [2:0]  rm_i = 3'd0;
  logic [7:0]  tag_i = 8'd0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic        result_sign_o;
  logic [7:0]  result_exp_o;
  logic [26:0] result_sig_o;
  logic        sig_is_zero_o;
  logic        a_lt_b_o;
  logic [7:0]  tag_o;

  always #5 clk = ~clk;

  near_path_pipe #(.EXPWIDTH(8), .PRECISION(48), .OUTPC(24), .TAGW(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_sign_i(a_sign_i), .a_exp_i(a_exp_i), .a_sig_i(a_sig_i),
    .b_sign_i(b_sign_i), .b_sig_i(b_sig_i), .need_shift_b_i(need_shift_b_i),
    .rm_i(rm_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_sign_o(result_sign_o), .result_exp_o(result_exp_o),
    .result_sig_o(result_sig_o), .sig_is_zero_o(sig_is_zero_o),
    .a_lt_b_o(a_lt_b_o), .tag_o(tag_o)
  );

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] sig;
    logic        zero;
    logic        alb;
    logic [7:0]  tag;
  } res_t;

  typedef struct packed {
    logic        sa;
    logic [7:0]  ea;
    logic [47:0] a;
    logic        sb;
    logic [47:0] b;
    logic        shb;
    logic [2:0]  rm;
    logic        sign;
    logic [7:0]  rexp;
    logic [26:0] rsig;
    logic        zero;
    logic        alb;
  } dir_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: unsigned magnitude compare and subtract, bit-scan normalise.
  function automatic res_t model(input logic sa, input logic [7:0] ea,
                                 input logic [47:0] sig_a, input logic sb,
                                 input logic [47:0] sig_b, input logic shb,
                                 input logic [2:0] rm, input logic [7:0] tag);
    res_t r;
    logic [63:0] av, bv, mag, nrm;
    int lz, sh, e;
    av = {16'd0, sig_a} << 1;
    bv = ({16'd0, sig_b} << 1) >> shb;
    if (av >= bv) begin mag = av - bv; r.alb = 1'b0; end
    else begin mag = bv - av; r.alb = 1'b1; end
    r.sign = r.alb ? sb : sa;
    lz = 49;
    for (int i = 0; i < 49; i++) if (mag[i]) lz = 48 - i;
    e = int'(ea);
    if (e == 0) sh = 0;
    else if (lz < e) sh = lz;
    else sh = e - 1;
    nrm = (mag << sh) & 64'h0001_FFFF_FFFF_FFFF;
    r.exp  = nrm[48] ? 8'(e - sh) : 8'd0;
    r.sig  = {nrm[48:23], |nrm[22:0]};
    r.zero = 1'b0;
    r.tag  = tag;
    if (mag == 64'd0) begin
      r.zero = 1'b1; r.exp = 8'd0; r.sig = 27'd0; r.sign = (rm == 3'b010);
    end
    return r;
  endfunction

  function automatic res_t observed();
    return {result_sign_o, result_exp_o, result_sig_o, sig_is_zero_o, a_lt_b_o, tag_o};
  endfunction

  // Drive one transaction (called at posedge+1) and hold it until accepted.
  task automatic apply(input logic sa, input logic [7:0] ea, input logic [47:0] sig_a,
                       input logic sb, input logic [47:0] sig_b, input logic shb,
                       input logic [2:0] rm, input logic [7:0] tag);
    bit done = 0;
    int guard = 0;
    a_sign_i = sa; a_exp_i = ea; a_sig_i = sig_a; b_sign_i = sb; b_sig_i = sig_b;
    need_shift_b_i = shb; rm_i = rm; tag_i = tag; in_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready_o) begin
        done = 1;
        exp_q.push_back(model(sa, ea, sig_a, sb, sig_b, shb, rm, tag));
      end
      @(posedge clk); #1;
      guard++;
      if (!done && guard > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL apply_timeout: tag %0h not accepted in %0d cycles", tag, guard);
        done = 1;
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid_o, observed()} !== 47'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", {out_valid_o, observed()});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    dir_t tbl[9];
    res_t got, mdl;
    tbl[0] = '{1'b0, 8'd10, 48'h800000000000, 1'b0, 48'h400000000000, 1'b0, 3'd0, 1'b0, 8'd9, 27'h4000000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd10, 48'h400000000000, 1'b1, 48'h800000000000, 1'b0, 3'd0, 1'b1, 8'd9, 27'h4000000, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'd10, 48'h123456789ABC, 1'b0, 48'h123456789ABC, 1'b0, 3'b010, 1'b1, 8'd0, 27'h0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'd10, 48'h123456789ABC, 1'b0, 48'h123456789ABC, 1'b0, 3'b000, 1'b0, 8'd0, 27'h0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'd3,  48'h800000000000, 1'b0, 48'h7C0000000000, 1'b0, 3'd0, 1'b0, 8'd0, 27'h0800000, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'd0,  48'h000001000000, 1'b0, 48'h000000000000, 1'b0, 3'd0, 1'b0, 8'd0, 27'h8, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'd20, 48'h800000000000, 1'b0, 48'hFFFFFFFFFFFF, 1'b1, 3'd0, 1'b1, 8'd0, 27'h1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'd6,  48'h800000000000, 1'b0, 48'h7C0000000000, 1'b0, 3'd0, 1'b0, 8'd1, 27'h4000000, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'd5,  48'h800000000000, 1'b0, 48'h7C0000000000, 1'b0, 3'd0, 1'b0, 8'd0, 27'h2000000, 1'b0, 1'b0};
    out_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].sa, tbl[i].ea, tbl[i].a, tbl[i].sb, tbl[i].b, tbl[i].shb, tbl[i].rm, 8'(8'h40 + i));
      @(negedge clk);
      n_cmp++;
      if (out_valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL dir%0d_latency: out_valid got %b expected 0 one cycle after accept", i, out_valid_o);
      end
      @(posedge clk); #1;
      @(negedge clk);
      got = observed();
      n_cmp++;
      if ({out_valid_o, got.sign, got.exp, got.sig, got.zero, got.alb, got.tag} !==
          {1'b1, tbl[i].sign, tbl[i].rexp, tbl[i].rsig, tbl[i].zero, tbl[i].alb, 8'(8'h40 + i)}) begin
        n_bad++;
        $display("FAIL dir%0d_result: got v=%b s=%b e=%0d sig=%h z=%b alb=%b tag=%h expected s=%b e=%0d sig=%h z=%b alb=%b",
                 i, out_valid_o, got.sign, got.exp, got.sig, got.zero, got.alb, got.tag,
                 tbl[i].sign, tbl[i].rexp, tbl[i].rsig, tbl[i].zero, tbl[i].alb);
      end
      mdl = exp_q.pop_front();
      n_cmp++;
      if (got !== mdl) begin
        n_bad++;
        $display("FAIL dir%0d_model: got %h expected %h", i, got, mdl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    res_t held, got, mdl;
    int n_got = 0;
    int guard = 0;
    out_ready_i = 1'b0;
    fork
      begin
        apply(1'b0, 8'd10, 48'h800000000000, 1'b0, 48'h400000000000, 1'b0, 3'd0, 8'd1);
        apply(1'b1, 8'd40, 48'hC00000000000, 1'b0, 48'hA12345678901, 1'b1, 3'd0, 8'd2);
        apply(1'b0, 8'd7,  48'h900000000000, 1'b1, 48'h8FFFFF000000, 1'b0, 3'd0, 8'd3);
      end
      begin
        repeat (3) @(negedge clk);
        held = observed();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready_o, out_valid_o, tag_o} !== {1'b0, 1'b1, 8'd1}) begin
          n_bad++;
          $display("FAIL bp_stall: in_ready=%b out_valid=%b tag=%h expected 0 1 01", in_ready_o, out_valid_o, tag_o);
        end
        n_cmp++;
        if (observed() !== held) begin
          n_bad++;
          $display("FAIL bp_hold: got %h expected %h", observed(), held);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        while (n_got < 3 && guard < 40) begin
          @(negedge clk);
          if (out_valid_o) begin
            got = observed();
            mdl = exp_q.pop_front();
            n_cmp++;
            if (got !== mdl || got.tag !== 8'(n_got + 1)) begin
              n_bad++;
              $display("FAIL bp_order%0d: got %h expected %h tag %0d", n_got, got, mdl, n_got + 1);
            end
            n_got++;
          end
          guard++;
        end
        n_cmp++;
        if (n_got != 3) begin
          n_bad++;
          $display("FAIL bp_count: got %0d results expected 3", n_got);
        end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready_i = 1'b1;
    apply(1'b0, 8'd10, 48'h800000000000, 1'b0, 48'h400000000000, 1'b0, 3'd0, 8'h20);
    a_sig_i = 48'hF00000000000; tag_i = 8'h21; in_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_in_ready: got %b expected 1", in_ready_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      if (out_valid_o) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL flush_outputs: got %0d valid cycles expected 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_midreset();
    int seen = 0;
    out_ready_i = 1'b1;
    apply(1'b0, 8'd10, 48'h800000000000, 1'b0, 48'h400000000000, 1'b0, 3'd0, 8'h30);
    apply(1'b0, 8'd12, 48'hA00000000000, 1'b0, 48'h500000000000, 1'b0, 3'd0, 8'h31);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid_o) seen++;
    end
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (out_valid_o) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %0d valid cycles expected 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    localparam int N = 40;
    res_t got, mdl;
    int n_got = 0;
    int guard = 0;
    out_ready_i = 1'b1;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          logic [63:0] r64, d64;
          logic [47:0] a, b;
          logic [7:0]  ea;
          r64 = {$urandom, $urandom};
          a = r64[47:0];
          a[47] = ($urandom_range(0, 7) != 0);
          d64 = 64'($urandom_range(0, 1000)) << $urandom_range(0, 40);
          case ($urandom_range(0, 3))
            0: begin r64 = {$urandom, $urandom}; b = r64[47:0]; end
            1: b = a - d64[47:0];
            2: b = a;
            default: b = a + d64[47:0];
          endcase
          ea = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(1, 254));
          apply(1'($urandom), ea, a, 1'($urandom), b, 1'($urandom), 3'($urandom_range(0, 4)), 8'(i));
        end
      end
      begin
        while (n_got < N && guard < 2000) begin
          @(negedge clk);
          if (out_valid_o && out_ready_i) begin
            got = observed();
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_bad++;
              $display("FAIL b2b_unexpected: got %h with empty scoreboard", got);
            end else begin
              mdl = exp_q.pop_front();
              if (got !== mdl) begin
                n_bad++;
                $display("FAIL b2b_result%0d: got %h expected %h", n_got, got, mdl);
              end
            end
            n_got++;
          end
          @(posedge clk); #1;
          out_ready_i = ($urandom_range(0, 3) != 0);
          guard++;
        end
        n_cmp++;
        if (n_got != N) begin
          n_bad++;
          $display("FAIL b2b_count: got %0d results expected %0d", n_got, N);
        end
      end
    join
    out_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_midreset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
